serial_link_rx: RTL and testbench



---
 rtl/serial_link_pkg.sv | 19 +
 rtl/serial_link_sync.sv | 30 +++
 rtl/serial_link_rx.sv | 169 ++++++++++++++++
 tb/tb_serial_link_rx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link receiver (and future transmitter).
package serial_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic IDLE_LEVEL = 1'b1;

  // Register width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_link_sync.sv
// Input synchronizer for the serial line, preset to idle level, with falling-edge detect.
module serial_link_sync
  import serial_link_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sdi_i,
  output logic sdi_s_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      prev_q <= IDLE_LEVEL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sdi_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sdi_s_o = sync_q[SYNC_STAGES-1];
  assign fall_o  = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/serial_link_rx.sv
// Serial link receiver: oversampled deframer with one-entry valid/ready buffer and sticky errors.
// Optional even parity bit enabled by defining SERIAL_LINK_RX_PARITY_EN.
module serial_link_rx
  import serial_link_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned OVS         = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SDI,
  input  logic              RDY_IN,
  input  logic              CLR_ERR,
  output logic [DATA_W-1:0] DOUT,
  output logic              VALID,
  output logic              FERR,
  output logic              PERR,
  output logic              OVR
);

  localparam int unsigned CW = cnt_width(OVS);
  localparam int unsigned BW = cnt_width(DATA_W + 1);

  logic              sdi_s;
  logic              fall;
  rx_state_t         state_q;
  logic [CW-1:0]     cnt_q;
  logic [BW-1:0]     bit_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [DATA_W-1:0] dout_q;
  logic              valid_q;
  logic              ferr_q;
  logic              ovr_q;
  logic              mid;
  logic              stop_smp;
  logic              parity_ok;
  logic              deliver;
  logic              take;

  serial_link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i   (CLK),
    .rst_i   (RST),
    .sdi_i   (SDI),
    .sdi_s_o (sdi_s),
    .fall_o  (fall)
  );

`ifdef SERIAL_LINK_RX_PARITY_EN
  logic par_q;
  logic perr_q;
  assign parity_ok = ~(^shift_q ^ par_q);
  assign PERR      = perr_q;
`else
  assign parity_ok = 1'b1;
  assign PERR      = 1'b0;
`endif

  always_comb begin
    shift_d           = shift_q >> 1;
    shift_d[DATA_W-1] = sdi_s;
  end

  // START samples at half a bit; every later state samples one full bit later.
  assign mid      = (state_q == START) ? (cnt_q == CW'(OVS/2 - 1)) : (cnt_q == CW'(OVS - 1));
  assign stop_smp = (state_q == STOP) && mid;
  assign deliver  = stop_smp && sdi_s && parity_ok;
  assign take     = valid_q && RDY_IN;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SERIAL_LINK_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (fall) begin
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (mid) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= (sdi_s == IDLE_LEVEL) ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (mid) begin
            cnt_q   <= '0;
            shift_q <= shift_d;
            if (bit_q == BW'(DATA_W - 1)) begin
`ifdef SERIAL_LINK_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bit_q <= bit_q + BW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`ifdef SERIAL_LINK_RX_PARITY_EN
        PARITY: begin
          if (mid) begin
            cnt_q   <= '0;
            par_q   <= sdi_s;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`endif
        STOP: begin
          if (mid) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase

      if (deliver && (!valid_q || RDY_IN)) begin
        dout_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (take) begin
        valid_q <= 1'b0;
      end

      // Clear first so a same-cycle set takes priority.
      if (CLR_ERR) begin
        ferr_q <= 1'b0;
        ovr_q  <= 1'b0;
`ifdef SERIAL_LINK_RX_PARITY_EN
        perr_q <= 1'b0;
`endif
      end
      if (stop_smp && !sdi_s) ferr_q <= 1'b1;
      if (deliver && valid_q && !RDY_IN) ovr_q <= 1'b1;
`ifdef SERIAL_LINK_RX_PARITY_EN
      if (stop_smp && sdi_s && !parity_ok) perr_q <= 1'b1;
`endif
    end
  end

  assign DOUT  = dout_q;
  assign VALID = valid_q;
  assign FERR  = ferr_q;
  assign OVR   = ovr_q;

endmodule

// File: tb/tb_serial_link_rx.sv
// Directed bench for serial_link_rx (DATA_W=8, OVS=8, SYNC_STAGES=2).
module tb_serial_link_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       SDI;
  logic       RDY_IN;
  logic       CLR_ERR;
  logic [7:0] DOUT;
  logic       VALID;
  logic       FERR;
  logic       PERR;
  logic       OVR;

  int tests = 0;
  int fails = 0;

  serial_link_rx #(
    .DATA_W      (8),
    .OVS         (8),
    .SYNC_STAGES (2)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .SDI     (SDI),
    .RDY_IN  (RDY_IN),
    .CLR_ERR (CLR_ERR),
    .DOUT    (DOUT),
    .VALID   (VALID),
    .FERR    (FERR),
    .PERR    (PERR),
    .OVR     (OVR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Start bit plus data (and parity when enabled); the caller drives the stop bit.
  // Start edge at P0+1 leads to the stop sample at edge P(start+stop_drive+7).
  task automatic frame_body(input logic [7:0] d, input logic par);
    SDI = 1'b0;
    ticks(8);
    for (int i = 0; i < 8; i++) begin
      SDI = d[i];
      ticks(8);
    end
`ifdef SERIAL_LINK_RX_PARITY_EN
    SDI = par;
    ticks(8);
`else
    if (par === 1'bx) SDI = 1'b0;
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    SDI     = 1'b1;
    RDY_IN  = 1'b1;
    CLR_ERR = 1'b0;
    RST     = 1'b1;
    ticks(3);
    check("rst_valid", VALID, 1'b0);
    check("rst_dout",  DOUT,  8'h00);
    check("rst_ferr",  FERR,  1'b0);
    check("rst_perr",  PERR,  1'b0);
    check("rst_ovr",   OVR,   1'b0);
    RST = 1'b0;
    ticks(2);

    // Good frame 0xA5, consumer ready: VALID one cycle after stop midpoint, one cycle wide.
    frame_body(8'hA5, 1'b0);
    SDI = 1'b1;
    ticks(6);
    check("a5_valid_early", VALID, 1'b0);
    tick();
    check("a5_valid", VALID, 1'b1);
    check("a5_dout",  DOUT,  8'hA5);
    tick();
    check("a5_valid_drop", VALID, 1'b0);
    check("a5_ferr", FERR, 1'b0);
    check("a5_ovr",  OVR,  1'b0);
    ticks(4);

    // 3-cycle glitch is rejected at the start midpoint.
    SDI = 1'b0;
    ticks(3);
    SDI = 1'b1;
    ticks(12);
    check("glitch_valid", VALID, 1'b0);
    check("glitch_ferr",  FERR,  1'b0);
    frame_body(8'hC3, 1'b0);
    SDI = 1'b1;
    ticks(7);
    check("c3_valid", VALID, 1'b1);
    check("c3_dout",  DOUT,  8'hC3);
    ticks(3);

    // Stop bit low: framing error, word dropped; CLR_ERR clears on next edge.
    frame_body(8'h3C, 1'b0);
    SDI = 1'b0;
    ticks(7);
    check("3c_ferr",  FERR,  1'b1);
    check("3c_valid", VALID, 1'b0);
    SDI = 1'b1;
    ticks(4);
    check("3c_ferr_sticky", FERR, 1'b1);
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    check("3c_ferr_clr", FERR, 1'b0);
    ticks(4);

    // Back-to-back frames with consumer stalled: second word overruns.
    RDY_IN = 1'b0;
    frame_body(8'h11, 1'b0);
    SDI = 1'b1;
    ticks(7);
    check("11_valid", VALID, 1'b1);
    check("11_dout",  DOUT,  8'h11);
    check("11_ovr",   OVR,   1'b0);
    tick();
    frame_body(8'h22, 1'b0);
    SDI = 1'b1;
    ticks(7);
    check("22_valid", VALID, 1'b1);
    check("22_dout",  DOUT,  8'h11);
    check("22_ovr",   OVR,   1'b1);
    RDY_IN = 1'b1;
    tick();
    check("hs_valid", VALID, 1'b0);
    check("hs_ovr_sticky", OVR, 1'b1);
    ticks(4);

    // Reset during data bit 4 of 0xFF clears outputs asynchronously.
    RDY_IN = 1'b0;
    SDI = 1'b0;
    ticks(8);
    SDI = 1'b1;
    ticks(36);
    #2;
    RST = 1'b1;
    #1;
    check("mid_rst_dout", DOUT,  8'h00);
    check("mid_rst_ovr",  OVR,   1'b0);
    check("mid_rst_valid", VALID, 1'b0);
    ticks(2);
    RST = 1'b0;
    RDY_IN = 1'b1;
    ticks(2);
    frame_body(8'h5A, 1'b0);
    SDI = 1'b1;
    ticks(7);
    check("5a_valid", VALID, 1'b1);
    check("5a_dout",  DOUT,  8'h5A);
    check("5a_ferr",  FERR,  1'b0);
    ticks(4);

`ifdef SERIAL_LINK_RX_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1.
    frame_body(8'h07, 1'b0);
    SDI = 1'b1;
    ticks(7);
    check("07_bad_perr",  PERR,  1'b1);
    check("07_bad_valid", VALID, 1'b0);
    ticks(2);
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    check("07_perr_clr", PERR, 1'b0);
    frame_body(8'h07, 1'b1);
    SDI = 1'b1;
    ticks(7);
    check("07_good_valid", VALID, 1'b1);
    check("07_good_dout",  DOUT,  8'h07);
    check("07_good_perr",  PERR,  1'b0);
    ticks(2);
`else
    check("perr_tied", PERR, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
